// File: rtl/uc_multiciclo_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
package uc_multiciclo_pkg;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_START,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_HALT
    } state_t;

    localparam logic [2:0] ULA_ADD = 3'b000;
    localparam logic [2:0] ULA_SUB = 3'b001;
    localparam logic [2:0] ULA_AND = 3'b010;
    localparam logic [2:0] ULA_OR  = 3'b011;
    localparam logic [2:0] ULA_SLT = 3'b101;

    localparam logic [1:0] ULAOP_ADD   = 2'b00;
    localparam logic [1:0] ULAOP_FUNCT = 2'b10;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] SRCA_PC   = 2'b00;
    localparam logic [1:0] SRCA_REGA = 2'b10;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ULAOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ULARESULT = 2'b10;

endpackage

// File: rtl/ula_decoder.sv
// ULA operation decoder: plain add, or funct-field decode for R/I arithmetic.
module ula_decoder
    import uc_multiciclo_pkg::*;
(
    input  logic [1:0] ula_op,
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [2:0] ula_control,
    output logic       funct_illegal
);

    logic [2:0] funct_ctrl;

    // op5 separates R-type from I-type, so addi can never become sub
    always_comb begin
        funct_ctrl    = ULA_ADD;
        funct_illegal = 1'b0;
        case (funct3)
            F3_ADDSUB: funct_ctrl = (op5 && funct7_5) ? ULA_SUB : ULA_ADD;
            F3_SLT:    funct_ctrl = ULA_SLT;
            F3_OR:     funct_ctrl = ULA_OR;
            F3_AND:    funct_ctrl = ULA_AND;
            default:   funct_illegal = 1'b1;
        endcase
        ula_control = (ula_op == ULAOP_FUNCT) ? funct_ctrl : ULA_ADD;
    end

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle control FSM for the shared-memory RISC-V datapath (lw/sw/R/I subset).
module uc_multiciclo
    import uc_multiciclo_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       OP,
    input  logic [2:0]       Funct3,
    input  logic [6:0]       Funct7,
    input  logic             MemAck,
    output logic             MemReq,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             ImmSrc,
    output logic [1:0]       ULASrcA,
    output logic [1:0]       ULASrcB,
    output logic [1:0]       ResultSrc,
    output logic [2:0]       ULAControl,
    output logic             InstrDone,
    output logic [CNT_W-1:0] InstrCount,
    output logic             Illegal
);

    state_t     state;
    state_t     state_next;
    logic [1:0] ula_op;
    logic [2:0] ula_ctrl_dec;
    logic       funct_illegal;
    logic       r_funct7_ok;

    ula_decoder u_ula_decoder (
        .ula_op        (ula_op),
        .op5           (OP[5]),
        .funct3        (Funct3),
        .funct7_5      (Funct7[5]),
        .ula_control   (ula_ctrl_dec),
        .funct_illegal (funct_illegal)
    );

    assign ULAControl  = ula_ctrl_dec;
    assign Illegal     = (state == S_HALT);
    // sub encoding is only valid together with funct3=000
    assign r_funct7_ok = (Funct7 == F7_BASE) || ((Funct7 == F7_ALT) && (Funct3 == F3_ADDSUB));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_START;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            InstrCount <= '0;
        end else if (InstrDone) begin
            InstrCount <= InstrCount + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        MemReq     = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ImmSrc     = 1'b0;
        ULASrcA    = SRCA_PC;
        ULASrcB    = SRCB_REGB;
        ResultSrc  = RES_ULAOUT;
        InstrDone  = 1'b0;
        ula_op     = ULAOP_ADD;

        case (state)
            S_START: state_next = S_FETCH;
            S_FETCH: begin
                MemReq    = 1'b1;
                ULASrcB   = SRCB_FOUR;
                ResultSrc = RES_ULARESULT;
                IRWrite   = MemAck;
                PCWrite   = MemAck;
                if (MemAck) state_next = S_DECODE;
            end
            S_DECODE: begin
                case (OP)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = (funct_illegal || !r_funct7_ok) ? S_HALT : S_EXECR;
                    OP_ITYPE:     state_next = funct_illegal ? S_HALT : S_EXECI;
                    default:      state_next = S_HALT;
                endcase
            end
            S_MEMADR: begin
                ULASrcA    = SRCA_REGA;
                ULASrcB    = SRCB_IMM;
                ImmSrc     = (OP == OP_SW);
                state_next = (OP == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                if (MemAck) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                InstrDone  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                MemReq    = 1'b1;
                MemWrite  = 1'b1;
                AdrSrc    = 1'b1;
                InstrDone = MemAck;
                if (MemAck) state_next = S_FETCH;
            end
            S_EXECR: begin
                ULASrcA    = SRCA_REGA;
                ULASrcB    = SRCB_REGB;
                ula_op     = ULAOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ULASrcA    = SRCA_REGA;
                ULASrcB    = SRCB_IMM;
                ula_op     = ULAOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc  = RES_ULAOUT;
                RegWrite   = 1'b1;
                InstrDone  = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_START;
        endcase
    end

endmodule
